// File: rtl/arcsine_taylor_if.sv
// Valid/ready stream bundle for the arcsine evaluator: sine value in, normalised angle out.
interface arcsine_taylor_if #(
  parameter int G_DWIDTH = 16
);
  logic signed [G_DWIDTH-1:0] din;
  logic                       din_valid;
  logic                       din_ready;
  logic signed [G_DWIDTH-1:0] dout;
  logic                       dout_valid;
  logic                       dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/arcsine_taylor.sv
// Streaming arcsine, dout = asin(x)*2/pi, 4-term Maclaurin series in Horner form on x^2.
// One shared multiplier serves the square, the three Horner steps and the final scale by x.
module arcsine_taylor #(
  parameter int G_DWIDTH   = 16,
  parameter int G_TAPWIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  arcsine_taylor_if.slave bus
);
  // state   | meaning
  // INIT    | arm din_ready | WAIT_IN accept x | SQUARE x^2 | HORNER 3 steps | FINAL acc*x, sat | SEND hold dout
  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT_IN,
    S_SQUARE,
    S_HORNER,
    S_FINAL,
    S_SEND
  } state_t;

  localparam int  CW    = G_TAPWIDTH + 1;
  localparam int  AW    = G_TAPWIDTH + 3;
  localparam int  XW    = G_DWIDTH + 1;
  localparam int  PW    = G_DWIDTH + G_TAPWIDTH + 4;
  localparam real SCALE = real'(longint'(1) << (G_TAPWIDTH - 1));

  localparam logic signed [CW-1:0] K0 = CW'($rtoi(0.63661977 * SCALE + 0.5));
  localparam logic signed [CW-1:0] K1 = CW'($rtoi(0.10610330 * SCALE + 0.5));
  localparam logic signed [CW-1:0] K2 = CW'($rtoi(0.04774648 * SCALE + 0.5));
  localparam logic signed [CW-1:0] K3 = CW'($rtoi(0.02842056 * SCALE + 0.5));

  localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (G_DWIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  state_t                     state_q, state_d;
  logic signed [G_DWIDTH-1:0] x_q, x_d;
  logic signed [XW-1:0]       x2_q, x2_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic signed [G_DWIDTH-1:0] dout_q, dout_d;
  logic                       din_ready_q, din_ready_d;
  logic                       dout_valid_q, dout_valid_d;

  logic signed [PW-1:0] mul_a, mul_b, mul_p;
  logic signed [PW-1:0] prod_dw, prod_tw;
  logic signed [PW-1:0] coef, horner_sum, y_sat;

  always_comb begin
    mul_a = PW'(x_q);
    mul_b = PW'(x_q);
    if (state_q == S_HORNER) begin
      mul_a = PW'(acc_q);
      mul_b = PW'(x2_q);
    end else if (state_q == S_FINAL) begin
      mul_a = PW'(acc_q);
    end
  end

  assign mul_p   = mul_a * mul_b;
  assign prod_dw = mul_p >>> (G_DWIDTH - 1);
  assign prod_tw = mul_p >>> (G_TAPWIDTH - 1);

  always_comb begin
    case (cnt_q)
      2'd2:    coef = PW'(K2);
      2'd1:    coef = PW'(K1);
      default: coef = PW'(K0);
    endcase
  end

  assign horner_sum = coef + prod_dw;

  always_comb begin
    y_sat = prod_tw;
    if (prod_tw > SAT_MAX)      y_sat = SAT_MAX;
    else if (prod_tw < SAT_MIN) y_sat = SAT_MIN;
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    x2_d         = x2_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    din_ready_d  = din_ready_q;
    dout_valid_d = dout_valid_q;
    if (!enable) begin
      state_d      = S_INIT;
      x_d          = '0;
      x2_d         = '0;
      acc_d        = '0;
      cnt_d        = '0;
      dout_d       = '0;
      din_ready_d  = 1'b0;
      dout_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          din_ready_d = 1'b1;
          state_d     = S_WAIT_IN;
        end
        S_WAIT_IN: begin
          if (bus.din_valid && din_ready_q) begin
            x_d         = bus.din;
            din_ready_d = 1'b0;
            acc_d       = AW'(K3);
            state_d     = S_SQUARE;
          end
        end
        S_SQUARE: begin
          x2_d    = XW'(prod_dw);
          cnt_d   = 2'd2;
          state_d = S_HORNER;
        end
        S_HORNER: begin
          acc_d = AW'(horner_sum);
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd0) state_d = S_FINAL;
        end
        S_FINAL: begin
          dout_d       = G_DWIDTH'(y_sat);
          dout_valid_d = 1'b1;
          state_d      = S_SEND;
        end
        S_SEND: begin
          if (bus.dout_ready) begin
            dout_valid_d = 1'b0;
            din_ready_d  = 1'b1;
            state_d      = S_WAIT_IN;
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_INIT;
      x_q          <= '0;
      x2_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      x2_q         <= x2_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_arcsine_taylor.sv
// Directed bench for arcsine_taylor: hand-computed vectors, latency, backpressure, reset and enable aborts.
module tb_arcsine_taylor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int hs_out = 0;
  int hs_in_cyc = 0;

  arcsine_taylor_if #(.G_DWIDTH(16)) bus ();

  arcsine_taylor #(.G_DWIDTH(16), .G_TAPWIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.dout_valid && bus.dout_ready) hs_out <= hs_out + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [31:0] obs, input int exp, input int tol);
    compared++;
    assert (!$isunknown(obs) && obs >= exp - tol && obs <= exp + tol) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Reference arithmetic: Q1.15 data, Q.15 taps, floor shifts, full-width products.
  function automatic int golden(input int x);
    longint k [0:3];
    longint x2, acc, y;
    k[0] = 20861; k[1] = 3477; k[2] = 1565; k[3] = 931;
    x2  = (longint'(x) * longint'(x)) >>> 15;
    acc = k[3];
    for (int c = 2; c >= 0; c--) acc = k[c] + ((acc * x2) >>> 15);
    y = (acc * longint'(x)) >>> 15;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  task automatic send(input logic signed [15:0] v);
    int n;
    n = 0;
    bus.din = v;
    bus.din_valid = 1'b1;
    while (!bus.din_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready", bus.din_ready, 1);
    tick();
    hs_in_cyc = cyc;
    bus.din_valid = 1'b0;
  endtask

  task automatic compute(input string tag, input logic signed [15:0] v, input int exp, input int tol);
    send(v);
    chk({tag, "_busy"}, bus.din_ready, 0);
    repeat (4) tick();
    chk({tag, "_early"}, bus.dout_valid, 0);
    chk({tag, "_busy4"}, bus.din_ready, 0);
    tick();
    chk({tag, "_valid"}, bus.dout_valid, 1);
    chk_tol({tag, "_dout"}, bus.dout, exp, tol);
    tick();
    chk({tag, "_drop"}, bus.dout_valid, 0);
    chk({tag, "_rdy"}, bus.din_ready, 1);
  endtask

  initial begin
    logic signed [15:0] stream [0:7];
    logic signed [15:0] held;
    int prev_cyc;
    int hs0;
    bit stable_ok;

    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (2) tick();
    chk("rst_din_ready", bus.din_ready, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout", bus.dout, 0);
    reset = 1'b1;
    tick();
    chk("init_ready", bus.din_ready, 1);

    compute("zero", 16'sd0, 0, 0);
    compute("half", 16'sd16384, 10921, 0);
    compute("neg_half", -16'sd16384, -10921, 0);
    compute("max", 16'sd32767, 26830, 0);
    compute("min", -16'sd32768, -26834, 0);

    // Backpressure with a competing input presented while busy.
    bus.dout_ready = 1'b0;
    send(16'sd8192);
    repeat (5) tick();
    chk("bp_valid", bus.dout_valid, 1);
    chk("bp_dout", bus.dout, 5271);
    held = bus.dout;
    bus.din = -16'sd8192;
    bus.din_valid = 1'b1;
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.dout !== held || bus.dout_valid !== 1'b1 || bus.din_ready !== 1'b0) stable_ok = 1'b0;
    end
    chk("bp_stable", stable_ok, 1);
    bus.dout_ready = 1'b1;
    tick();
    chk("bp_release_rdy", bus.din_ready, 1);
    chk("bp_release_valid", bus.dout_valid, 0);
    tick();
    bus.din_valid = 1'b0;
    chk("bp_next_taken", bus.din_ready, 0);
    repeat (5) tick();
    chk("bp_next_valid", bus.dout_valid, 1);
    chk("bp_next_dout", bus.dout, -5271);
    tick();

    stream[0] = 16'sd1234;   stream[1] = -16'sd20000; stream[2] = 16'sd30000; stream[3] = -16'sd5;
    stream[4] = 16'sd7;      stream[5] = -16'sd31000; stream[6] = 16'sd12000; stream[7] = 16'sd25000;
    prev_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      compute($sformatf("stream%0d", i), stream[i], golden(int'(stream[i])), 2);
      if (i > 0) chk($sformatf("period%0d", i), hs_in_cyc - prev_cyc, 7);
      prev_cyc = hs_in_cyc;
    end

    // Asynchronous reset while the Horner loop is running.
    send(16'sd20000);
    repeat (2) tick();
    #3;
    reset = 1'b0;
    #1;
    chk("arst_din_ready", bus.din_ready, 0);
    chk("arst_dout_valid", bus.dout_valid, 0);
    chk("arst_dout", bus.dout, 0);
    #2;
    reset = 1'b1;
    tick();
    chk("arst_init_ready", bus.din_ready, 1);
    compute("after_rst", 16'sd16384, 10921, 0);

    // Enable dropped while the result waits in SEND.
    bus.dout_ready = 1'b0;
    send(16'sd16384);
    repeat (5) tick();
    chk("en_send_valid", bus.dout_valid, 1);
    hs0 = hs_out;
    enable = 1'b0;
    tick();
    chk("en_valid", bus.dout_valid, 0);
    chk("en_dout", bus.dout, 0);
    chk("en_din_ready", bus.din_ready, 0);
    chk("en_no_hs", hs_out, hs0);
    enable = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    chk("en_init_ready", bus.din_ready, 1);
    compute("after_en", -16'sd16384, -10921, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
